jtframe_prog_packer: RTL

//   Buffers the byte-wide ROM download stream (ioctl_*) from the HPS and issues

---
 rtl/jtframe_prog_packer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/jtframe_prog_packer.sv
// jtframe_prog_packer
//   Buffers the byte-wide HPS ROM download stream in a small FIFO and replays
//   it towards the SDRAM programming port with a request/ready handshake.
//   Bytes at or above PROM_START are sent to a one-cycle PROM write strobe
//   instead, and they do not use the handshake. dwnld_busy stays high while
//   a download is open or still draining, plus a short hold-off afterwards.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   downloading          HPS download window
//   ioctl_addr/data/wr   incoming byte address, byte and one-cycle valid strobe
//   prog_addr/data/mask  registered write address, byte and active-low lane mask
//   prog_we / prog_rdy   SDRAM write request (held) and write-done pulse
//   prom_we              one-cycle PROM write strobe
//   dwnld_busy           download in progress, draining or in hold-off
//   overflow             sticky flag: a byte was dropped on a full FIFO
module jtframe_prog_packer #(
    parameter int          FIFO_AW     = 2,
    parameter logic [21:0] PROM_START  = 22'h3F_0000,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        overflow
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PROM  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [29:0]      fifo_mem_q [DEPTH];
    logic [29:0]      fifo_mem_d [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [21:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       mask_q, mask_d;
    logic             overflow_q, overflow_d;
    logic             dl_q, dl_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;

    logic        fifo_empty, fifo_full;
    logic        push_req, push_ok, push_drop, pop;
    logic [29:0] head;
    logic [21:0] head_addr;
    logic        head_is_prom;
    logic        active;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                          (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign head         = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign head_addr    = head[29:8];
    assign head_is_prom = (head_addr >= PROM_START);

    assign pop       = (state_q == ST_IDLE) && !fifo_empty;
    assign push_req  = ioctl_wr && downloading;
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;

    assign active     = downloading || !fifo_empty || (state_q != ST_IDLE);
    assign dwnld_busy = active || (hold_cnt_q != 8'd0);

    // FIFO storage and pointers
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q[FIFO_AW-1:0]] = {ioctl_addr, ioctl_data};
        end
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = head_is_prom ? ST_PROM : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (prog_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROM:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        prog_we = (state_q == ST_WRITE);
        prom_we = (state_q == ST_PROM);
    end

    // Output datapath, overflow flag and busy hold-off
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        mask_d = mask_q;
        if (pop) begin
            addr_d = head_is_prom ? (head_addr - PROM_START) : {1'b0, head_addr[21:1]};
            data_d = head[7:0];
            mask_d = head_addr[0] ? 2'b01 : 2'b10;
        end

        dl_d       = downloading;
        overflow_d = overflow_q;
        if (downloading && !dl_q) begin
            overflow_d = 1'b0;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
        end

        // Kept loaded while active so the count starts at HOLD_CYCLES on the
        // first inactive cycle and busy never dips between the two phases.
        if (active) begin
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
        end else begin
            hold_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
            dl_q       <= 1'b0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            overflow_q <= overflow_d;
            dl_q       <= dl_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign prog_addr = addr_q;
    assign prog_data = data_q;
    assign prog_mask = mask_q;
    assign overflow  = overflow_q;

endmodule
